scan_reg_bank: RTL and testbench



---
 rtl/scan_pkg.sv | 23 ++
 rtl/scan_shift_reg.sv | 60 ++++++
 rtl/scan_reg_bank.sv | 98 +++++++++
 tb/tb_scan_reg_bank.sv | 139 +++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan register bank.
//   scan_state_t : scan controller states (FUNC, CAPTURE, SHIFT, UPDATE)
//   cnt_w()      : width of the saturating shift counter for a given chain length
package scan_pkg;

    localparam logic [1:0] ST_FUNC    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    typedef enum logic [1:0] {
        FUNC    = ST_FUNC,
        CAPTURE = ST_CAPTURE,
        SHIFT   = ST_SHIFT,
        UPDATE  = ST_UPDATE
    } scan_state_t;

    // Counter must reach WIDTH+1 (saturation value), so it needs WIDTH+2 codes.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Shadow scan chain with parallel capture and right shift, plus a saturating
// shift counter that reports whether exactly WIDTH shifts have occurred.
// Ports:
//   Clk, Clr    : clock, synchronous active-high clear
//   cap_i       : parallel load par_i into shadow, clear the counter
//   shift_i     : shift right, tdi_i into the MSB, count one shift
//   par_i       : parallel capture data
//   tdi_i       : serial input
//   shadow_o    : shadow register contents (bit 0 drives tdo)
//   len_ok_o    : shift count equals WIDTH
module scan_shift_reg
    import scan_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             cap_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             tdi_i,
    output logic [WIDTH-1:0] shadow_o,
    output logic             len_ok_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (cap_i) begin
            shadow_d = par_i;
            cnt_d    = '0;
        end else if (shift_i) begin
            if (WIDTH > 1) shadow_d = {tdi_i, shadow_q[WIDTH-1:1]};
            else           shadow_d = tdi_i;
            // Saturate one past WIDTH so any over-length sequence stays "not ok".
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = shadow_q;
    assign len_ok_o = (cnt_q == CNT_FULL);

endmodule

// File: rtl/scan_reg_bank.sv
// WIDTH functional output flops with a TAP-style shadow scan chain.
// A single mode pin (tms) steps FUNC -> CAPTURE -> SHIFT* -> UPDATE -> FUNC.
// Ports:
//   Clk, Clr  : clock, synchronous active-high clear (priority over all)
//   d, en     : functional next-state data and load enable (FUNC only)
//   tms, tdi  : scan mode select and serial input
//   q         : functional register outputs
//   tdo       : serial output (shadow bit 0, so q[0] emerges first)
//   scan_busy : controller is outside FUNC
//   len_err   : sticky; a shift sequence of length != WIDTH was seen
module scan_reg_bank
    import scan_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit UPDATE_EN = 1'b1,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             tms,
    input  logic             tdi,
    output logic [WIDTH-1:0] q,
    output logic             tdo,
    output logic             scan_busy,
    output logic             len_err
);

    scan_state_t      state_q;
    logic [WIDTH-1:0] q_q;
    logic             busy_q;
    logic             len_err_q;
    logic [WIDTH-1:0] shadow;
    logic             len_ok;
    logic             cap, shift;

    assign cap   = (state_q == CAPTURE);
    assign shift = (state_q == SHIFT) && tms;

    scan_shift_reg #(.WIDTH(WIDTH)) u_chain (
        .Clk      (Clk),
        .Clr      (Clr),
        .cap_i    (cap),
        .shift_i  (shift),
        .par_i    (q_q),
        .tdi_i    (tdi),
        .shadow_o (shadow),
        .len_ok_o (len_ok)
    );

    // Single FSM block; scan_busy is registered alongside the next state.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q   <= FUNC;
            q_q       <= {WIDTH{RESET_VAL}};
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            case (state_q)
                FUNC: begin
                    if (en) q_q <= d;
                    if (tms) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    if (!tms) state_q <= UPDATE;
                    busy_q <= 1'b1;
                end
                UPDATE: begin
                    if (len_ok) begin
                        if (UPDATE_EN) q_q <= shadow;
                    end else begin
                        len_err_q <= 1'b1;
                    end
                    state_q <= FUNC;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= FUNC;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign tdo       = shadow[0];
    assign scan_busy = busy_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_scan_reg_bank.sv
module tb_scan_reg_bank;

    logic       Clk = 1'b0;
    logic       Clr, en, tms, tdi;
    logic [2:0] d;
    logic [2:0] q, q0;
    logic       tdo, tdo0, busy, busy0, lerr, lerr0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    scan_reg_bank #(.WIDTH(3), .UPDATE_EN(1'b1), .RESET_VAL(1'b0)) dut (
        .Clk(Clk), .Clr(Clr), .d(d), .en(en), .tms(tms), .tdi(tdi),
        .q(q), .tdo(tdo), .scan_busy(busy), .len_err(lerr)
    );

    scan_reg_bank #(.WIDTH(3), .UPDATE_EN(1'b0), .RESET_VAL(1'b0)) dut0 (
        .Clk(Clk), .Clr(Clr), .d(d), .en(en), .tms(tms), .tdi(tdi),
        .q(q0), .tdo(tdo0), .scan_busy(busy0), .len_err(lerr0)
    );

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Clr = 1'b1; en = 1'b1; d = 3'b111; tms = 1'b0; tdi = 1'b0;
        tick(); tick();
        n_chk++; if (q !== 3'b000) $display("FAIL reset_q got %b exp 000", q); else n_pass++;
        n_chk++; if (tdo !== 1'b0) $display("FAIL reset_tdo got %b exp 0", tdo); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (lerr !== 1'b0) $display("FAIL reset_lerr got %b exp 0", lerr); else n_pass++;
        n_chk++; if (q0 !== 3'b000) $display("FAIL reset_q0 got %b exp 000", q0); else n_pass++;
        Clr = 1'b0; d = 3'b101; en = 1'b1;
        tick();
        n_chk++; if (q !== 3'b101) $display("FAIL func_load got %b exp 101", q); else n_pass++;
        en = 1'b0; d = 3'b010;
        tick();
        n_chk++; if (q !== 3'b101) $display("FAIL func_hold got %b exp 101", q); else n_pass++;
    endtask

    task automatic test_observe();
        en = 1'b1; d = 3'b110;
        tick();
        en = 1'b0;
        n_chk++; if (q !== 3'b110) $display("FAIL obs_preload got %b exp 110", q); else n_pass++;
        tms = 1'b1;
        tick();                                   // -> CAPTURE
        n_chk++; if (busy !== 1'b1) $display("FAIL obs_busy_cap got %b exp 1", busy); else n_pass++;
        tick();                                   // CAPTURE edge: shadow = 110
        n_chk++; if (tdo !== 1'b0) $display("FAIL obs_tdo0 got %b exp 0", tdo); else n_pass++;
        tdi = 1'b0; tick();                       // shadow 011
        n_chk++; if (tdo !== 1'b1) $display("FAIL obs_tdo1 got %b exp 1", tdo); else n_pass++;
        tdi = 1'b1; tick();                       // shadow 101
        n_chk++; if (tdo !== 1'b1) $display("FAIL obs_tdo2 got %b exp 1", tdo); else n_pass++;
        tdi = 1'b1; tick();                       // shadow 110 (recirculated)
        n_chk++; if (q !== 3'b110) $display("FAIL obs_q_mid got %b exp 110", q); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL obs_busy_shift got %b exp 1", busy); else n_pass++;
        tms = 1'b0; tick();                       // -> UPDATE
        n_chk++; if (busy !== 1'b1) $display("FAIL obs_busy_upd got %b exp 1", busy); else n_pass++;
        tick();                                   // UPDATE edge -> FUNC
        n_chk++; if (busy !== 1'b0) $display("FAIL obs_busy_end got %b exp 0", busy); else n_pass++;
        n_chk++; if (q !== 3'b110) $display("FAIL obs_q_end got %b exp 110", q); else n_pass++;
        n_chk++; if (lerr !== 1'b0) $display("FAIL obs_lerr got %b exp 0", lerr); else n_pass++;
    endtask

    task automatic test_load();
        en = 1'b1; d = 3'b000;
        tick();
        tms = 1'b1;
        tick();                                   // FUNC edge loads 000, -> CAPTURE
        d = 3'b111;                               // must be ignored from here on
        tick();                                   // shadow = 000
        tdi = 1'b1; tick();                       // 100
        tdi = 1'b0; tick();                       // 010
        n_chk++; if (q !== 3'b000) $display("FAIL load_q_mid got %b exp 000", q); else n_pass++;
        tdi = 1'b1; tick();                       // 101
        n_chk++; if (tdo !== 1'b1) $display("FAIL load_tdo got %b exp 1", tdo); else n_pass++;
        n_chk++; if (tdo0 !== 1'b1) $display("FAIL load_tdo0 got %b exp 1", tdo0); else n_pass++;
        tms = 1'b0; tick();                       // -> UPDATE
        n_chk++; if (q !== 3'b000) $display("FAIL load_q_preupd got %b exp 000", q); else n_pass++;
        tick();                                   // UPDATE edge
        en = 1'b0;
        n_chk++; if (q !== 3'b101) $display("FAIL load_q got %b exp 101", q); else n_pass++;
        n_chk++; if (q0 !== 3'b000) $display("FAIL noupd_q0 got %b exp 000", q0); else n_pass++;
        n_chk++; if (lerr !== 1'b0) $display("FAIL load_lerr got %b exp 0", lerr); else n_pass++;
        n_chk++; if (lerr0 !== 1'b0) $display("FAIL noupd_lerr0 got %b exp 0", lerr0); else n_pass++;
    endtask

    task automatic test_len_err();
        tms = 1'b1; tick(); tick();               // CAPTURE, then SHIFT
        tdi = 1'b1; tick(); tick();               // 2 shifts only
        tms = 1'b0; tick(); tick();               // UPDATE -> FUNC
        n_chk++; if (q !== 3'b101) $display("FAIL len2_q got %b exp 101", q); else n_pass++;
        n_chk++; if (lerr !== 1'b1) $display("FAIL len2_lerr got %b exp 1", lerr); else n_pass++;
        tms = 1'b1; tick(); tick();               // correct 3-bit scan of zeros
        tdi = 1'b0; tick(); tick(); tick();
        tms = 1'b0; tick(); tick();
        n_chk++; if (q !== 3'b000) $display("FAIL len3_q got %b exp 000", q); else n_pass++;
        n_chk++; if (lerr !== 1'b1) $display("FAIL len_sticky got %b exp 1", lerr); else n_pass++;
        Clr = 1'b1; tick(); Clr = 1'b0;
        n_chk++; if (lerr !== 1'b0) $display("FAIL len_clr got %b exp 0", lerr); else n_pass++;
        // zero-length shift
        en = 1'b1; d = 3'b011; tick(); en = 1'b0;
        tms = 1'b1; tick(); tms = 1'b0; tick(); tick(); tick();
        n_chk++; if (lerr !== 1'b1) $display("FAIL len0_lerr got %b exp 1", lerr); else n_pass++;
        n_chk++; if (q !== 3'b011) $display("FAIL len0_q got %b exp 011", q); else n_pass++;
        Clr = 1'b1; tick(); Clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b1; d = 3'b011; tick(); en = 1'b0;
        tms = 1'b1; tick(); tick();               // CAPTURE, SHIFT
        tdi = 1'b1; tick();                       // 1st shift
        Clr = 1'b1; tick();
        n_chk++; if (q !== 3'b000) $display("FAIL mid_q got %b exp 000", q); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (tdo !== 1'b0) $display("FAIL mid_tdo got %b exp 0", tdo); else n_pass++;
        Clr = 1'b0; tms = 1'b0; tick(); tick();
        n_chk++; if (q !== 3'b000) $display("FAIL mid_q_after got %b exp 000", q); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy_after got %b exp 0", busy); else n_pass++;
        n_chk++; if (lerr !== 1'b0) $display("FAIL mid_lerr got %b exp 0", lerr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_observe();
        test_load();
        test_len_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
